// File: rtl/i8254_bus_ctrl.sv
// i8254_bus_ctrl: CPU-side bus sequencer for an 8254 timer.
// Decodes control words, keeps the per-counter {rw,mode,bcd} fields, assembles
// byte writes into 16-bit count loads, and serves counter-latch and read traffic.
// Optional read-back command (SC=11) is compiled in with `define I8254_READBACK_EN.
module i8254_bus_ctrl #(
    parameter logic [5:0] RESET_CW = 6'b000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    input  logic        a0,
    input  logic        a1,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        cs_n,
    input  logic [47:0] count_in,
    input  logic [2:0]  out_in,
    input  logic [2:0]  ce_loaded,
    output logic [17:0] cw_out,
    output logic [2:0]  cw_stb,
    output logic [15:0] load_val,
    output logic [2:0]  load_stb
);

    localparam logic [1:0] RW_NONE = 2'b00;
    localparam logic [1:0] RW_LSB  = 2'b01;
    localparam logic [1:0] RW_MSB  = 2'b10;
    localparam logic [1:0] RW_WORD = 2'b11;
    localparam logic [1:0] A_CTRL  = 2'b11;

    // Bus transaction tracking
    logic        wr_pend_q;
    logic        rd_pend_q;
    logic        rd_kill_q;
    logic [1:0]  wr_addr_q;
    logic [7:0]  wr_data_q;
    logic [1:0]  rd_addr_q;
    logic        wr_commit;
    logic        rd_commit;
    logic [1:0]  wr_sc;
    logic [1:0]  wr_rw;

    // Per-counter state
    logic [5:0]  cw_q      [3];
    logic        wptr_q    [3];   // 1: next count write is the MSB
    logic        rptr_q    [3];   // 1: next read returns the MSB
    logic [7:0]  hold_q    [3];   // LSB waiting for its MSB
    logic        cl_full_q [3];
    logic [15:0] cl_val_q  [3];
    logic [2:0]  null_q;
    logic [2:0]  cw_stb_q;
    logic [2:0]  load_stb_q;
    logic [15:0] load_val_q;
    logic [15:0] cnt       [3];

`ifdef I8254_READBACK_EN
    logic        st_full_q [3];
    logic [7:0]  st_val_q  [3];
`else
    logic        unused_rb;
    assign unused_rb = ^{out_in, null_q};
`endif

    // Modes 6 and 7 alias modes 2 and 3; store the canonical encoding.
    function automatic logic [5:0] fold_cw(input logic [7:0] d);
        logic [2:0] m;
        m = d[3:1];
        if (m[2] && m[1]) begin
            m[2] = 1'b0;
        end
        return {d[5:4], m, d[0]};
    endfunction

    assign wr_sc     = wr_data_q[7:6];
    assign wr_rw     = wr_data_q[5:4];
    assign wr_commit = wr_pend_q && wr_n;
    assign rd_commit = rd_pend_q && rd_n && !cs_n && !rd_kill_q && (rd_addr_q != A_CTRL);

    assign cw_out   = {cw_q[2], cw_q[1], cw_q[0]};
    assign cw_stb   = cw_stb_q;
    assign load_stb = load_stb_q;
    assign load_val = load_val_q;

    // Split the packed live counts into per-counter words.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cnt[i] = count_in[16*i +: 16];
        end
    end

    // Strobe edge tracking: a write or read is pending while its strobe is low;
    // a read that overlaps a write is marked dead until rd_n goes high.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_pend_q <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_kill_q <= 1'b0;
        end else begin
            wr_pend_q <= !wr_n && !cs_n;
            rd_pend_q <= !rd_n && !cs_n;
            rd_kill_q <= (!rd_n && !cs_n) && (!wr_n || (rd_pend_q && rd_kill_q));
        end
    end

    // Capture address/data while the strobes are active.
    always_ff @(posedge clk) begin
        if (!wr_n && !cs_n) begin
            wr_addr_q <= {a1, a0};
            wr_data_q <= data_in;
        end
        if (!rd_n && !cs_n) begin
            rd_addr_q <= {a1, a0};
        end
    end

    // Commit reads and writes into the per-counter state and issue strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                cw_q[i]      <= RESET_CW;
                wptr_q[i]    <= 1'b0;
                rptr_q[i]    <= 1'b0;
                cl_full_q[i] <= 1'b0;
`ifdef I8254_READBACK_EN
                st_full_q[i] <= 1'b0;
`endif
            end
            null_q     <= 3'b111;
            cw_stb_q   <= 3'b000;
            load_stb_q <= 3'b000;
            load_val_q <= 16'h0000;
        end else begin
            cw_stb_q   <= 3'b000;
            load_stb_q <= 3'b000;

            for (int i = 0; i < 3; i++) begin
                if (ce_loaded[i]) begin
                    null_q[i] <= 1'b0;
                end
            end

            // Reads first so a write in the same cycle takes precedence.
            if (rd_commit) begin
`ifdef I8254_READBACK_EN
                if (st_full_q[rd_addr_q]) begin
                    st_full_q[rd_addr_q] <= 1'b0;
                end else
`endif
                begin
                    if (cw_q[rd_addr_q][5:4] == RW_WORD) begin
                        rptr_q[rd_addr_q] <= !rptr_q[rd_addr_q];
                        if (rptr_q[rd_addr_q]) begin
                            cl_full_q[rd_addr_q] <= 1'b0;
                        end
                    end else begin
                        cl_full_q[rd_addr_q] <= 1'b0;
                    end
                end
            end

            if (wr_commit) begin
                if (wr_addr_q == A_CTRL) begin
                    if (wr_sc != 2'b11) begin
                        if (wr_rw != RW_NONE) begin
                            cw_q[wr_sc]      <= fold_cw(wr_data_q);
                            wptr_q[wr_sc]    <= 1'b0;
                            rptr_q[wr_sc]    <= 1'b0;
                            cl_full_q[wr_sc] <= 1'b0;
`ifdef I8254_READBACK_EN
                            st_full_q[wr_sc] <= 1'b0;
`endif
                            null_q[wr_sc]    <= 1'b1;
                            cw_stb_q[wr_sc]  <= 1'b1;
                        end else if (!cl_full_q[wr_sc]) begin
                            cl_full_q[wr_sc] <= 1'b1;
                            cl_val_q[wr_sc]  <= cnt[wr_sc];
                        end
                    end
`ifdef I8254_READBACK_EN
                    else begin
                        // Read-back: d[5]/d[4] are active-low count/status selects.
                        for (int i = 0; i < 3; i++) begin
                            if (wr_data_q[i+1]) begin
                                if (!wr_data_q[5] && !cl_full_q[i]) begin
                                    cl_full_q[i] <= 1'b1;
                                    cl_val_q[i]  <= cnt[i];
                                end
                                if (!wr_data_q[4] && !st_full_q[i]) begin
                                    st_full_q[i] <= 1'b1;
                                    st_val_q[i]  <= {out_in[i], null_q[i], cw_q[i]};
                                end
                            end
                        end
                    end
`endif
                end else begin
                    case (cw_q[wr_addr_q][5:4])
                        RW_LSB: begin
                            load_val_q            <= {8'h00, wr_data_q};
                            load_stb_q[wr_addr_q] <= 1'b1;
                            null_q[wr_addr_q]     <= 1'b1;
                        end
                        RW_MSB: begin
                            load_val_q            <= {wr_data_q, 8'h00};
                            load_stb_q[wr_addr_q] <= 1'b1;
                            null_q[wr_addr_q]     <= 1'b1;
                        end
                        RW_WORD: begin
                            if (!wptr_q[wr_addr_q]) begin
                                hold_q[wr_addr_q] <= wr_data_q;
                                wptr_q[wr_addr_q] <= 1'b1;
                            end else begin
                                load_val_q            <= {wr_data_q, hold_q[wr_addr_q]};
                                load_stb_q[wr_addr_q] <= 1'b1;
                                null_q[wr_addr_q]     <= 1'b1;
                                wptr_q[wr_addr_q]     <= 1'b0;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    // Read data path: status byte, latched count or live count, byte-selected by rw.
    logic [1:0]  rsel;
    logic [15:0] rsrc;
    always_comb begin
        data_oe  = !rd_n && !cs_n && !(a1 && a0);
        data_out = 8'h00;
        rsel     = {a1, a0};
        rsrc     = 16'h0000;
        if (data_oe) begin
            rsrc = cl_full_q[rsel] ? cl_val_q[rsel] : cnt[rsel];
            case (cw_q[rsel][5:4])
                RW_LSB:  data_out = rsrc[7:0];
                RW_MSB:  data_out = rsrc[15:8];
                RW_WORD: data_out = rptr_q[rsel] ? rsrc[15:8] : rsrc[7:0];
                default: data_out = 8'h00;
            endcase
`ifdef I8254_READBACK_EN
            if (st_full_q[rsel]) begin
                data_out = st_val_q[rsel];
            end
`endif
        end
    end

endmodule

// File: tb/tb_i8254_bus_ctrl.sv
// Self-checking bench for i8254_bus_ctrl: directed scenarios plus a randomized
// run against a byte-queue reference model of the bus behaviour.
module tb_i8254_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        data_oe;
    logic        a0, a1, rd_n, wr_n, cs_n;
    logic [47:0] count_in;
    logic [2:0]  out_in;
    logic [2:0]  ce_loaded;
    logic [17:0] cw_out;
    logic [2:0]  cw_stb;
    logic [15:0] load_val;
    logic [2:0]  load_stb;

    int total = 0;
    int bad   = 0;

    i8254_bus_ctrl dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
        .a0(a0), .a1(a1), .rd_n(rd_n), .wr_n(wr_n), .cs_n(cs_n),
        .count_in(count_in), .out_in(out_in), .ce_loaded(ce_loaded),
        .cw_out(cw_out), .cw_stb(cw_stb), .load_val(load_val), .load_stb(load_stb)
    );

    always #5 clk = ~clk;

    // Reference model: programmed fields, write/read byte order, and the
    // latched bytes still owed to the CPU kept as a queue per counter.
    logic [1:0] m_rw   [3];
    logic [2:0] m_mode [3];
    logic       m_bcd  [3];
    bit         m_whi  [3];
    logic [7:0] m_hold [3];
    bit         m_rhi  [3];
    logic [7:0] m_lq   [3][$];

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        {a1, a0} = 2'b00; data_in = 8'h00; ce_loaded = 3'b000; out_in = 3'b000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d,
                             output logic [5:0] pre, output logic [2:0] cws,
                             output logic [2:0] lds, output logic [15:0] lv,
                             output logic [5:0] post);
        @(negedge clk);
        cs_n = 1'b0; {a1, a0} = a; data_in = d; wr_n = 1'b0;
        @(negedge clk);
        pre = {cw_stb, load_stb};
        wr_n = 1'b1;
        @(negedge clk);
        cws = cw_stb; lds = load_stb; lv = load_val;
        cs_n = 1'b1;
        @(negedge clk);
        post = {cw_stb, load_stb};
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d, output logic oe);
        @(negedge clk);
        cs_n = 1'b0; {a1, a0} = a; rd_n = 1'b0;
        #1;
        d = data_out; oe = data_oe;
        @(negedge clk);
        rd_n = 1'b1;
        @(negedge clk);
        cs_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] d; logic oe;
        do_reset();
        total++; if (cw_out !== 18'h0) begin bad++; $display("FAIL reset_cw_out: got %h want %h", cw_out, 18'h0); end
        total++; if ({cw_stb, load_stb} !== 6'b0) begin bad++; $display("FAIL reset_strobes: got %b want 0", {cw_stb, load_stb}); end
        total++; if (load_val !== 16'h0) begin bad++; $display("FAIL reset_load_val: got %h want 0000", load_val); end
        count_in = {$urandom, $urandom};
        bus_read(2'b00, d, oe);
        total++; if (d !== 8'h00 || oe !== 1'b1) begin bad++; $display("FAIL reset_read0: got %h oe=%b want 00 oe=1", d, oe); end
    endtask

    task automatic test_cw_load16();
        logic [5:0] pre, post; logic [2:0] cws, lds; logic [15:0] lv;
        do_reset();
        bus_write(2'b11, 8'h34, pre, cws, lds, lv, post);
        total++; if (cws !== 3'b001 || pre !== 6'b0 || post !== 6'b0) begin bad++; $display("FAIL cw34_stb: got pre=%b stb=%b post=%b want 0/001/0", pre, cws, post); end
        total++; if (cw_out[5:0] !== 6'b110100) begin bad++; $display("FAIL cw34_field: got %b want 110100", cw_out[5:0]); end
        bus_write(2'b00, 8'h12, pre, cws, lds, lv, post);
        total++; if (lds !== 3'b000 || cws !== 3'b000) begin bad++; $display("FAIL load_lsb_only: got lds=%b cws=%b want 000", lds, cws); end
        bus_write(2'b00, 8'h34, pre, cws, lds, lv, post);
        total++; if (lds !== 3'b001 || pre !== 6'b0 || post !== 6'b0) begin bad++; $display("FAIL load16_stb: got pre=%b stb=%b post=%b want 0/001/0", pre, lds, post); end
        total++; if (lv !== 16'h3412) begin bad++; $display("FAIL load16_val: got %h want 3412", lv); end
    endtask

    task automatic test_rw01();
        logic [5:0] pre, post; logic [2:0] cws, lds; logic [15:0] lv;
        bus_write(2'b11, 8'h50, pre, cws, lds, lv, post);
        total++; if (cws !== 3'b010 || cw_out[11:6] !== 6'b010000) begin bad++; $display("FAIL cw50: got stb=%b field=%b want 010/010000", cws, cw_out[11:6]); end
        bus_write(2'b01, 8'hAB, pre, cws, lds, lv, post);
        total++; if (lds !== 3'b010 || pre !== 6'b0 || post !== 6'b0) begin bad++; $display("FAIL rw01_stb: got pre=%b stb=%b post=%b want 0/010/0", pre, lds, post); end
        total++; if (lv !== 16'h00AB) begin bad++; $display("FAIL rw01_val: got %h want 00ab", lv); end
    endtask

    task automatic test_latch();
        logic [5:0] pre, post; logic [2:0] cws, lds; logic [15:0] lv; logic [7:0] d; logic oe;
        do_reset();
        bus_write(2'b11, 8'hB0, pre, cws, lds, lv, post);
        count_in[47:32] = 16'hBEEF;
        bus_write(2'b11, 8'h80, pre, cws, lds, lv, post);
        total++; if (cws !== 3'b000 || cw_out[17:12] !== 6'b110000) begin bad++; $display("FAIL latch_no_cw: got stb=%b field=%b want 000/110000", cws, cw_out[17:12]); end
        count_in[47:32] = 16'h1111;
        bus_read(2'b10, d, oe);
        total++; if (d !== 8'hEF) begin bad++; $display("FAIL latch_lsb: got %h want ef", d); end
        bus_read(2'b10, d, oe);
        total++; if (d !== 8'hBE) begin bad++; $display("FAIL latch_msb: got %h want be", d); end
        bus_read(2'b10, d, oe);
        total++; if (d !== 8'h11) begin bad++; $display("FAIL latch_live: got %h want 11", d); end
    endtask

    task automatic test_double_latch();
        logic [5:0] pre, post; logic [2:0] cws, lds; logic [15:0] lv; logic [7:0] d; logic oe;
        bus_write(2'b11, 8'hB0, pre, cws, lds, lv, post);
        count_in[47:32] = 16'hCAFE;
        bus_write(2'b11, 8'h80, pre, cws, lds, lv, post);
        count_in[47:32] = 16'h1234;
        bus_write(2'b11, 8'h80, pre, cws, lds, lv, post);
        count_in[47:32] = 16'h5678;
        bus_read(2'b10, d, oe);
        total++; if (d !== 8'hFE) begin bad++; $display("FAIL dlatch_lsb: got %h want fe", d); end
        bus_read(2'b10, d, oe);
        total++; if (d !== 8'hCA) begin bad++; $display("FAIL dlatch_msb: got %h want ca", d); end
    endtask

    task automatic test_mode_fold();
        logic [5:0] pre, post; logic [2:0] cws, lds; logic [15:0] lv;
        bus_write(2'b11, 8'h5D, pre, cws, lds, lv, post);
        total++; if (cw_out[11:6] !== 6'b010101) begin bad++; $display("FAIL mode6_fold: got %b want 010101", cw_out[11:6]); end
        bus_write(2'b11, 8'h9F, pre, cws, lds, lv, post);
        total++; if (cw_out[17:12] !== 6'b010111) begin bad++; $display("FAIL mode7_fold: got %b want 010111", cw_out[17:12]); end
    endtask

    task automatic test_rw00_ignored();
        logic [5:0] pre, post; logic [2:0] cws, lds; logic [15:0] lv;
        do_reset();
        bus_write(2'b01, 8'h44, pre, cws, lds, lv, post);
        total++; if (lds !== 3'b000 || post !== 6'b0) begin bad++; $display("FAIL rw00_write: got stb=%b post=%b want 000", lds, post); end
    endtask

    task automatic test_cs_drop();
        logic [5:0] pre, post; logic [2:0] cws, lds; logic [15:0] lv; logic [5:0] s1, s2;
        bus_write(2'b11, 8'h50, pre, cws, lds, lv, post);
        @(negedge clk); cs_n = 1'b0; {a1, a0} = 2'b01; data_in = 8'h5A; wr_n = 1'b0;
        @(negedge clk); cs_n = 1'b1;
        @(negedge clk); wr_n = 1'b1;
        @(negedge clk); s1 = {cw_stb, load_stb};
        @(negedge clk); s2 = {cw_stb, load_stb};
        total++; if ((s1 | s2) !== 6'b0) begin bad++; $display("FAIL cs_drop: got %b/%b want 0", s1, s2); end
    endtask

    task automatic test_collide();
        logic [5:0] pre, post; logic [2:0] cws, lds; logic [15:0] lv; logic [7:0] d; logic oe;
        do_reset();
        bus_write(2'b11, 8'h30, pre, cws, lds, lv, post);
        count_in[15:0] = 16'hA5C3;
        bus_write(2'b11, 8'h00, pre, cws, lds, lv, post);
        count_in[15:0] = 16'h0F0F;
        @(negedge clk); cs_n = 1'b0; {a1, a0} = 2'b00; data_in = 8'h77; rd_n = 1'b0; wr_n = 1'b0;
        @(negedge clk); rd_n = 1'b1; wr_n = 1'b1;
        @(negedge clk); lds = load_stb; cs_n = 1'b1;
        total++; if (lds !== 3'b000) begin bad++; $display("FAIL collide_lsb: got %b want 000", lds); end
        bus_read(2'b00, d, oe);
        total++; if (d !== 8'hC3) begin bad++; $display("FAIL collide_rd_lsb: got %h want c3", d); end
        bus_read(2'b00, d, oe);
        total++; if (d !== 8'hA5) begin bad++; $display("FAIL collide_rd_msb: got %h want a5", d); end
        bus_write(2'b00, 8'h99, pre, cws, lds, lv, post);
        total++; if (lds !== 3'b001 || lv !== 16'h9977) begin bad++; $display("FAIL collide_load: got %b %h want 001 9977", lds, lv); end
    endtask

    task automatic test_reset_mid();
        logic [5:0] pre, post; logic [2:0] cws, lds; logic [15:0] lv; logic [5:0] s1, s2;
        do_reset();
        bus_write(2'b11, 8'h50, pre, cws, lds, lv, post);
        @(negedge clk); cs_n = 1'b0; {a1, a0} = 2'b01; data_in = 8'h66; wr_n = 1'b0;
        @(negedge clk); rst = 1'b1; wr_n = 1'b1;
        @(negedge clk); rst = 1'b0; cs_n = 1'b1; s1 = {cw_stb, load_stb};
        @(negedge clk); s2 = {cw_stb, load_stb};
        total++; if ((s1 | s2) !== 6'b0 || cw_out !== 18'h0) begin bad++; $display("FAIL reset_mid: got stb=%b/%b cw=%h want 0", s1, s2, cw_out); end
    endtask

    task automatic test_readback();
        logic [5:0] pre, post; logic [2:0] cws, lds; logic [15:0] lv; logic [7:0] d; logic oe;
        logic [15:0] v, w;
        do_reset();
        bus_write(2'b11, 8'h36, pre, cws, lds, lv, post);
        bus_write(2'b00, 8'h21, pre, cws, lds, lv, post);
        bus_write(2'b00, 8'h43, pre, cws, lds, lv, post);
        @(negedge clk); ce_loaded = 3'b001;
        @(negedge clk); ce_loaded = 3'b000;
        out_in = 3'b001;
        v = 16'($urandom); w = ~v;
        count_in[15:0] = v;
        bus_write(2'b11, 8'hC2, pre, cws, lds, lv, post);
        total++; if (cws !== 3'b000 || lds !== 3'b000 || cw_out !== {12'h000, 6'b110110}) begin bad++; $display("FAIL rb_cmd_side: got stb=%b/%b cw=%h want 0/0/%h", cws, lds, cw_out, {12'h000, 6'b110110}); end
        count_in[15:0] = w;
`ifdef I8254_READBACK_EN
        bus_read(2'b00, d, oe);
        total++; if (d !== 8'hB6) begin bad++; $display("FAIL rb_status: got %h want b6", d); end
        bus_read(2'b00, d, oe);
        total++; if (d !== v[7:0]) begin bad++; $display("FAIL rb_lsb: got %h want %h", d, v[7:0]); end
        bus_read(2'b00, d, oe);
        total++; if (d !== v[15:8]) begin bad++; $display("FAIL rb_msb: got %h want %h", d, v[15:8]); end
        bus_read(2'b00, d, oe);
        total++; if (d !== w[7:0]) begin bad++; $display("FAIL rb_after: got %h want %h", d, w[7:0]); end
`else
        bus_read(2'b00, d, oe);
        total++; if (d !== w[7:0]) begin bad++; $display("FAIL rb_off_lsb: got %h want %h", d, w[7:0]); end
        bus_read(2'b00, d, oe);
        total++; if (d !== w[15:8]) begin bad++; $display("FAIL rb_off_msb: got %h want %h", d, w[15:8]); end
`endif
    endtask

    function automatic logic [7:0] live_byte(input int c);
        logic [15:0] v;
        v = count_in[16*c +: 16];
        if (m_rw[c] == 2'd1) return v[7:0];
        if (m_rw[c] == 2'd2) return v[15:8];
        if (m_rw[c] == 2'd3) return m_rhi[c] ? v[15:8] : v[7:0];
        return 8'h00;
    endfunction

    task automatic test_random();
        logic [5:0] pre, post; logic [2:0] cws, lds; logic [15:0] lv; logic [7:0] d, rd; logic oe;
        logic [2:0] exp_lds; logic [15:0] exp_lv, v; logic [17:0] exp_cw; logic [7:0] exp_rd;
        int op, c;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            m_rw[i] = 2'd0; m_mode[i] = 3'd0; m_bcd[i] = 1'b0;
            m_whi[i] = 0; m_rhi[i] = 0; m_hold[i] = 8'h00; m_lq[i].delete();
        end
        for (int k = 0; k < 240; k++) begin
            op = (k < 3) ? 0 : int'($urandom_range(0, 9));
            c  = (k < 3) ? k : int'($urandom_range(0, 2));
            count_in = {$urandom, $urandom};
            if (op <= 1) begin
                d = {2'(c), 2'($urandom_range(1, 3)), 3'($urandom), 1'($urandom)};
                m_rw[c] = d[5:4];
                m_mode[c] = (d[3:1] >= 3'd6) ? d[3:1] - 3'd4 : d[3:1];
                m_bcd[c] = d[0];
                m_whi[c] = 0; m_rhi[c] = 0; m_lq[c].delete();
                bus_write(2'b11, d, pre, cws, lds, lv, post);
                exp_cw = {m_rw[2], m_mode[2], m_bcd[2], m_rw[1], m_mode[1], m_bcd[1], m_rw[0], m_mode[0], m_bcd[0]};
                total++; if (cws !== 3'(1 << c) || lds !== 3'b000 || post !== 6'b0) begin bad++; $display("FAIL rnd_cw_stb: d=%h got %b want %b", d, cws, 3'(1 << c)); end
                total++; if (cw_out !== exp_cw) begin bad++; $display("FAIL rnd_cw_out: d=%h got %h want %h", d, cw_out, exp_cw); end
            end else if (op == 2) begin
                d = {2'(c), 2'b00, 4'($urandom)};
                v = count_in[16*c +: 16];
                if (m_lq[c].size() == 0) begin
                    if (m_rw[c] == 2'd1) m_lq[c].push_back(v[7:0]);
                    else if (m_rw[c] == 2'd2) m_lq[c].push_back(v[15:8]);
                    else if (m_rhi[c]) m_lq[c].push_back(v[15:8]);
                    else begin m_lq[c].push_back(v[7:0]); m_lq[c].push_back(v[15:8]); end
                end
                bus_write(2'b11, d, pre, cws, lds, lv, post);
                total++; if (cws !== 3'b000 || lds !== 3'b000) begin bad++; $display("FAIL rnd_latch_stb: got %b/%b want 0", cws, lds); end
            end else if (op <= 5) begin
                d = 8'($urandom);
                exp_lds = 3'b000; exp_lv = 16'h0000;
                if (m_rw[c] == 2'd1) begin exp_lds = 3'(1 << c); exp_lv = {8'h00, d}; end
                else if (m_rw[c] == 2'd2) begin exp_lds = 3'(1 << c); exp_lv = {d, 8'h00}; end
                else if (!m_whi[c]) begin m_hold[c] = d; m_whi[c] = 1; end
                else begin exp_lds = 3'(1 << c); exp_lv = {d, m_hold[c]}; m_whi[c] = 0; end
                bus_write(2'(c), d, pre, cws, lds, lv, post);
                total++; if (lds !== exp_lds || pre !== 6'b0 || post !== 6'b0) begin bad++; $display("FAIL rnd_load_stb: c=%0d got %b want %b", c, lds, exp_lds); end
                if (exp_lds != 3'b000) begin
                    total++; if (lv !== exp_lv) begin bad++; $display("FAIL rnd_load_val: c=%0d got %h want %h", c, lv, exp_lv); end
                end
            end else begin
                exp_rd = (m_lq[c].size() > 0) ? m_lq[c][0] : live_byte(c);
                bus_read(2'(c), rd, oe);
                if (m_lq[c].size() > 0) void'(m_lq[c].pop_front());
                if (m_rw[c] == 2'd3) m_rhi[c] = !m_rhi[c];
                total++; if (rd !== exp_rd || oe !== 1'b1) begin bad++; $display("FAIL rnd_read: c=%0d got %h oe=%b want %h", c, rd, oe, exp_rd); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; a0 = 1'b0; a1 = 1'b0;
        data_in = 8'h00; count_in = 48'h0; out_in = 3'b000; ce_loaded = 3'b000;
        test_reset();
        test_cw_load16();
        test_rw01();
        test_latch();
        test_double_latch();
        test_mode_fold();
        test_rw00_ignored();
        test_cs_drop();
        test_collide();
        test_reset_mid();
        test_readback();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
